det_scheduler: RTL and testbench
================================

Name: det_scheduler

Overview:
- Shares one serial pattern detector (`x` in, 2-bit `y` out) among N_CH serial requesters.
- Round-robin arbiter grants one channel per transaction. The controller clears the detector, steers the granted channel's bit onto the detector input, captures the first non-zero classification, and returns it over a valid/ready result port.
- Sits between the serial front-end channels and the shared detector instance.

Parameters:
- N_CH, 4, number of requesting channels (2..8)
- CH_W, $clog2(N_CH), width of the channel index
- TIMEOUT, 32, RUN-state cycle limit (used only with DET_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N_CH  per-channel request; held high for the whole transaction
- x_in  in  N_CH  per-channel serial bit
- gnt  out  N_CH  one-hot grant
- det_x  out  1  serial bit to the detector
- det_rst  out  1  synchronous clear pulse to the detector
- det_y  in  2  detector code: 00 none, 01 "010", 10 "0110", 11 "01110"
- res_valid  out  1  result available
- res_code  out  2  captured detector code
- res_ch  out  CH_W  channel that produced the result
- res_timeout  out  1  result was produced by timeout (always 0 without the macro)
- res_ready  in  1  consumer accepts the result

Behaviour:
- Reset values: gnt=0, det_x=0, det_rst=1, res_valid=0, res_code=0, res_ch=0, res_timeout=0, rr pointer=0, state=IDLE.
- States: IDLE, CLR, RUN, HOLD. All outputs are registered.
- IDLE:
  - if req!=0, pick the first set req at or after the rr pointer (wrapping N_CH-1 to 0).
  - Load gnt one-hot and go to CLR.
- CLR: det_rst=1 for exactly one cycle, det_x=0, then go to RUN.
- RUN:
  - det_x = x_in[granted] registered (1-cycle delay).
  - When det_y!=00: capture res_code=det_y and res_ch=granted index, set res_valid=1, go to HOLD.
  - Latency: grant to first forwarded bit is 2 cycles.
- HOLD:
  - Hold all result fields stable while res_valid=1 && res_ready=0.
  - On res_ready=1: clear res_valid and gnt, set rr pointer = granted+1 (wraps), go to IDLE.
- Abort: if req[granted] drops in CLR or RUN, go to IDLE with no result and clear gnt. The rr pointer still advances.
- In HOLD, dropping req is ignored; the result must still be consumed.
- det_y!=00 is ignored in CLR (detector state is stale). Only RUN samples det_y.
- Simultaneous: a new req arriving in the same cycle HOLD completes is arbitrated in IDLE on the next cycle. There is no back-to-back grant without passing through IDLE.
- gnt is never multi-hot. det_rst is high in reset, IDLE and CLR; low in RUN and HOLD.
- Asynchronous reset mid-transaction drops the result and returns all outputs to reset values immediately.

Optional Feature:
- DET_TIMEOUT_EN
- Defined: an 8-bit-wide (or wider, if TIMEOUT needs it) cycle counter runs in RUN.
  - On reaching TIMEOUT with det_y still 00: res_code=00, res_timeout=1, res_valid=1, go to HOLD.
  - The counter clears on entry to RUN.
- Undefined: RUN waits indefinitely (exit only on a hit or abort), no counter logic, res_timeout tied 0.

Decomposition:
- Package det_sched_pkg:
  - state enum {IDLE, CLR, RUN, HOLD}
  - code constants CODE_NONE=2'b00, CODE_010=2'b01, CODE_0110=2'b10, CODE_01110=2'b11
  - default TIMEOUT
- Sub-module rr_arbiter:
  - inputs: req, pointer, enable
  - output: one-hot grant plus encoded index
  - combinational rotate/priority/unrotate
- The bench instantiates det_scheduler together with the existing detector.

Test Plan:
- Single channel: ch0 req=1, sends 0,1,0 → gnt=0001, det_rst pulse 1 cycle, res_valid=1 with res_code=01, res_ch=0; res_ready=1 → IDLE, gnt=0.
- Round-robin: req=1111 held, each sends 0,1,1,0 with res_ready tied 1 → grant order ch0,ch1,ch2,ch3,ch0; every res_code=10.
- Backpressure: ch2 sends 0,1,1,1,0, res_ready=0 for 10 cycles → res_valid, res_code=11, res_ch=2 stable for all 10 cycles; ch1 req waits until release.
- Abort: ch1 granted, drops req mid-RUN after 0,1 → no res_valid, gnt=0 next cycle, next grant goes to ch2 even if ch1 re-requests.
- Reset mid-HOLD: rst=1 for 55 ns while res_valid=1 → res_valid=0, gnt=0, det_rst=1 asynchronously; after release the pointer is at 0.
- DET_TIMEOUT_EN, TIMEOUT=32: ch3 holds x=0 → res_valid after 32 RUN cycles with res_code=00, res_timeout=1; without the macro, no result after 100 cycles.

Source files
------------

// File: rtl/det_sched_pkg.sv
// rtl/det_sched_pkg.sv - shared types and constants for the detector scheduler
package det_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CLR  = 2'd1,
      RUN  = 2'd2,
      HOLD = 2'd3
   } state_t;

   localparam logic [1:0] CODE_NONE  = 2'b00;
   localparam logic [1:0] CODE_010   = 2'b01;
   localparam logic [1:0] CODE_0110  = 2'b10;
   localparam logic [1:0] CODE_01110 = 2'b11;

   localparam int DEFAULT_TIMEOUT = 32;

   // RUN cycle counter is at least 8 bits, wider only if TIMEOUT needs it
   function automatic int cnt_width(input int timeout);
      cnt_width = ($clog2(timeout + 1) > 8) ? $clog2(timeout + 1) : 8;
   endfunction

endpackage

// File: rtl/det_scheduler_if.sv
// rtl/det_scheduler_if.sv - requester, detector and result signals of the scheduler
interface det_sched_if #(
   parameter int N_CH = 4,
   parameter int CH_W = $clog2(N_CH)
);
   logic [N_CH-1:0] req;
   logic [N_CH-1:0] x_in;
   logic [N_CH-1:0] gnt;
   logic            det_x;
   logic            det_rst;
   logic [1:0]      det_y;
   logic            res_valid;
   logic [1:0]      res_code;
   logic [CH_W-1:0] res_ch;
   logic            res_timeout;
   logic            res_ready;

   modport master (
      input  req, x_in, det_y, res_ready,
      output gnt, det_x, det_rst, res_valid, res_code, res_ch, res_timeout
   );

   modport slave (
      output req, x_in, det_y, res_ready,
      input  gnt, det_x, det_rst, res_valid, res_code, res_ch, res_timeout
   );
endinterface

// File: rtl/det_scheduler_rr_arbiter.sv
// rtl/det_scheduler_rr_arbiter.sv - combinational round-robin arbiter
// First set request at or after the pointer wins, wrapping N_CH-1 to 0.
module rr_arbiter #(
   parameter int N_CH = 4,
   parameter int CH_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [CH_W-1:0] pointer,
   input  logic            enable,
   output logic [N_CH-1:0] grant,
   output logic [CH_W-1:0] index
);

   logic [N_CH-1:0] rot;
   logic [CH_W:0]   j;
   logic [CH_W:0]   sum;
   logic [CH_W-1:0] pos;
   logic            found;

   always_comb begin
      rot   = '0;
      j     = '0;
      pos   = '0;
      found = 1'b0;
      // rotate so the pointer position lands on bit 0
      for (int i = 0; i < N_CH; i++) begin
         j = {1'b0, pointer} + (CH_W+1)'(i);
         if (j >= (CH_W+1)'(N_CH))
            j = j - (CH_W+1)'(N_CH);
         rot[i] = req[j[CH_W-1:0]];
      end
      for (int i = 0; i < N_CH; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            pos   = CH_W'(i);
         end
      end
      sum = {1'b0, pos} + {1'b0, pointer};
      if (sum >= (CH_W+1)'(N_CH))
         sum = sum - (CH_W+1)'(N_CH);
      index = '0;
      grant = '0;
      if (enable && found) begin
         index        = sum[CH_W-1:0];
         grant[index] = 1'b1;
      end
   end

endmodule

// File: rtl/det_scheduler.sv
// rtl/det_scheduler.sv - round-robin scheduler sharing one serial pattern detector
// Optional RUN-state timeout is enabled by defining DET_TIMEOUT_EN.
module det_scheduler
   import det_sched_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int CH_W    = $clog2(N_CH),
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input logic         clk,
   input logic         rst,
   det_sched_if.master bus
);

   if (N_CH < 2 || N_CH > 8 || TIMEOUT < 1) begin : g_cfg_err
      $error("det_scheduler: unsupported N_CH or TIMEOUT");
   end

   state_t          state, state_nxt;
   logic [N_CH-1:0] gnt_q, gnt_nxt, arb_gnt;
   logic [CH_W-1:0] idx_q, idx_nxt, arb_idx;
   logic [CH_W-1:0] ptr_q, ptr_nxt, idx_inc;
   logic            det_x_q, det_x_nxt;
   logic            det_rst_q, det_rst_nxt;
   logic            res_valid_q, res_valid_nxt;
   logic [1:0]      res_code_q, res_code_nxt;
   logic [CH_W-1:0] res_ch_q, res_ch_nxt;
   logic            req_lost, hit, timeout_hit;

   assign req_lost = ~bus.req[idx_q];
   assign hit      = (bus.det_y != CODE_NONE);
   assign idx_inc  = (idx_q == CH_W'(N_CH - 1)) ? '0 : idx_q + CH_W'(1);

   rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
      .req     (bus.req),
      .pointer (ptr_q),
      .enable  (state == IDLE),
      .grant   (arb_gnt),
      .index   (arb_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         gnt_q       <= '0;
         idx_q       <= '0;
         ptr_q       <= '0;
         det_x_q     <= 1'b0;
         det_rst_q   <= 1'b1;
         res_valid_q <= 1'b0;
         res_code_q  <= CODE_NONE;
         res_ch_q    <= '0;
      end else begin
         state       <= state_nxt;
         gnt_q       <= gnt_nxt;
         idx_q       <= idx_nxt;
         ptr_q       <= ptr_nxt;
         det_x_q     <= det_x_nxt;
         det_rst_q   <= det_rst_nxt;
         res_valid_q <= res_valid_nxt;
         res_code_q  <= res_code_nxt;
         res_ch_q    <= res_ch_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (|arb_gnt) state_nxt = CLR;
         CLR:  state_nxt = req_lost ? IDLE : RUN;
         RUN: begin
            if (req_lost)
               state_nxt = IDLE;
            else if (hit || timeout_hit)
               state_nxt = HOLD;
         end
         HOLD: if (bus.res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt_nxt       = gnt_q;
      idx_nxt       = idx_q;
      ptr_nxt       = ptr_q;
      det_x_nxt     = 1'b0;
      det_rst_nxt   = (state_nxt == IDLE) || (state_nxt == CLR);
      res_valid_nxt = res_valid_q;
      res_code_nxt  = res_code_q;
      res_ch_nxt    = res_ch_q;
      case (state)
         IDLE: begin
            if (|arb_gnt) begin
               gnt_nxt = arb_gnt;
               idx_nxt = arb_idx;
            end
         end
         CLR: begin
            if (req_lost) begin
               gnt_nxt = '0;
               ptr_nxt = idx_inc;
            end
         end
         RUN: begin
            if (req_lost) begin
               gnt_nxt = '0;
               ptr_nxt = idx_inc;
            end else begin
               det_x_nxt = bus.x_in[idx_q];
               // det_y is only trusted here; in CLR it still reflects the previous channel
               if (hit || timeout_hit) begin
                  res_valid_nxt = 1'b1;
                  res_code_nxt  = bus.det_y;
                  res_ch_nxt    = idx_q;
               end
            end
         end
         HOLD: begin
            if (bus.res_ready) begin
               res_valid_nxt = 1'b0;
               gnt_nxt       = '0;
               ptr_nxt       = idx_inc;
            end
         end
         default: ;
      endcase
   end

`ifdef DET_TIMEOUT_EN
   localparam int CNT_W = cnt_width(TIMEOUT);

   logic [CNT_W-1:0] run_cnt;
   logic             res_to_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_cnt  <= '0;
         res_to_q <= 1'b0;
      end else begin
         run_cnt <= (state == RUN) ? run_cnt + CNT_W'(1) : '0;
         // leaving RUN for HOLD without a detector hit can only mean timeout
         if (state == RUN && state_nxt == HOLD)
            res_to_q <= ~hit;
      end
   end

   assign timeout_hit     = (state == RUN) && (run_cnt == CNT_W'(TIMEOUT - 1));
   assign bus.res_timeout = res_to_q;
`else
   assign timeout_hit     = 1'b0;
   assign bus.res_timeout = 1'b0;
`endif

   assign bus.gnt       = gnt_q;
   assign bus.det_x     = det_x_q;
   assign bus.det_rst   = det_rst_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_code  = res_code_q;
   assign bus.res_ch    = res_ch_q;

endmodule

// File: tb/tb_det_scheduler.sv
// tb/tb_det_scheduler.sv - scoreboard bench for det_scheduler with a serial detector model
module tb_det_scheduler;
   import det_sched_pkg::*;

   localparam int N_CH    = 4;
   localparam int CH_W    = 2;
   localparam int TIMEOUT = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   det_sched_if #(.N_CH(N_CH), .CH_W(CH_W)) bus ();

   det_scheduler #(.N_CH(N_CH), .CH_W(CH_W), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // detector model: clears on det_rst, then classifies the newest bits
   logic [4:0] hist;
   logic [2:0] hl;

   function automatic logic [1:0] classify(input logic [4:0] h, input logic [2:0] n);
      if (n >= 3'd5 && h == 5'b01110) return CODE_01110;
      if (n >= 3'd4 && h[3:0] == 4'b0110) return CODE_0110;
      if (n >= 3'd3 && h[2:0] == 3'b010) return CODE_010;
      return CODE_NONE;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst || bus.det_rst) begin
         hist      <= '0;
         hl        <= '0;
         bus.det_y <= CODE_NONE;
      end else begin
         hist      <= {hist[3:0], bus.det_x};
         hl        <= (hl == 3'd5) ? 3'd5 : hl + 3'd1;
         bus.det_y <= classify({hist[3:0], bus.det_x}, (hl == 3'd5) ? 3'd5 : hl + 3'd1);
      end
   end

   // serial front-ends: granted channel plays its pattern once the detector is out of clear
   logic [7:0] pat  [N_CH];
   int         plen [N_CH];
   logic       pad  [N_CH];
   int         fe_pos = 0;

   always @(negedge clk) begin
      for (int i = 0; i < N_CH; i++) bus.x_in[i] = 1'b1;
      if (bus.det_rst || bus.gnt == '0) begin
         fe_pos = 0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (bus.gnt[i]) bus.x_in[i] = (fe_pos < plen[i]) ? pat[i][fe_pos] : pad[i];
         end
         fe_pos++;
      end
   end

   typedef struct {
      int ch;
      int code;
      int to;
   } res_t;

   res_t sb[$];
   int   exp_gnt_q[$];

   logic [N_CH-1:0] prev_gnt = '0;
   bit              chk_clr = 1'b0;
   int              e_gnt;
   res_t            e_res;

   always @(negedge clk) begin
      #2;
      if (chk_clr) begin
         check("det_rst_low_after_clr", bus.det_rst, 0);
         chk_clr = 1'b0;
      end
      if (bus.gnt != '0 && prev_gnt == '0) begin
         check("gnt_onehot", $countones(bus.gnt), 1);
         check("det_rst_in_clr", bus.det_rst, 1);
         if (exp_gnt_q.size() == 0) begin
            check("unexpected_grant", bus.gnt, 0);
         end else begin
            e_gnt = exp_gnt_q.pop_front();
            check("grant", bus.gnt, 1 << e_gnt);
         end
         chk_clr = 1'b1;
      end
      prev_gnt = bus.gnt;
      if (bus.res_valid && bus.res_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_result", bus.res_valid, 0);
         end else begin
            e_res = sb.pop_front();
            check("res_ch", bus.res_ch, e_res.ch);
            check("res_code", bus.res_code, e_res.code);
            check("res_timeout", bus.res_timeout, e_res.to);
         end
      end
   end

   task automatic set_pat(input int ch, input logic [7:0] p, input int l, input logic pd);
      pat[ch]  = p;
      plen[ch] = l;
      pad[ch]  = pd;
   endtask

   task automatic push_res(input int ch, input int code, input int to);
      res_t r;
      r.ch   = ch;
      r.code = code;
      r.to   = to;
      sb.push_back(r);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // bounded waits; each returns at the negedge where its condition holds
   task automatic wait_hs(input string tag);
      int n = 0;
      while (!(bus.res_valid && bus.res_ready) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!(bus.res_valid && bus.res_ready)) check({tag, "_handshake"}, 0, 1);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!bus.res_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!bus.res_valid) check({tag, "_valid"}, bus.res_valid, 1);
   endtask

   task automatic wait_gnt(input string tag);
      int n = 0;
      while (bus.gnt == '0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.gnt == '0) check({tag, "_grant_wait"}, bus.gnt, 1);
   endtask

   task automatic wait_run(input string tag);
      int n = 0;
      while (bus.det_rst && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.det_rst) check({tag, "_run_wait"}, bus.det_rst, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int n;
      bit seen;
      bus.req       = '0;
      bus.res_ready = 1'b0;
      for (int i = 0; i < N_CH; i++) set_pat(i, 8'h00, 0, 1'b0);

      repeat (2) @(negedge clk);
      check("rst_gnt", bus.gnt, 0);
      check("rst_det_x", bus.det_x, 0);
      check("rst_det_rst", bus.det_rst, 1);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_res_code", bus.res_code, 0);
      check("rst_res_ch", bus.res_ch, 0);
      check("rst_res_timeout", bus.res_timeout, 0);
      rst = 1'b0;

      // single channel, pattern 010
      set_pat(0, 8'b010, 3, 1'b0);
      exp_gnt_q.push_back(0);
      push_res(0, 1, 0);
      bus.res_ready = 1'b1;
      bus.req = 4'b0001;
      wait_hs("t1");
      bus.req = '0;
      repeat (2) @(negedge clk);
      check("t1_idle_gnt", bus.gnt, 0);

      // round robin with all channels requesting, pattern 0110
      do_reset();
      for (int i = 0; i < N_CH; i++) set_pat(i, 8'b0110, 4, 1'b0);
      for (int k = 0; k < 5; k++) begin
         exp_gnt_q.push_back(k % N_CH);
         push_res(k % N_CH, 2, 0);
      end
      bus.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_hs("t2");
         if (k == 4) bus.req = '0;
         @(negedge clk);
      end

      // backpressure on a 01110 result while ch1 waits
      do_reset();
      bus.res_ready = 1'b0;
      set_pat(2, 8'b01110, 5, 1'b0);
      set_pat(1, 8'b010, 3, 1'b0);
      exp_gnt_q.push_back(2);
      exp_gnt_q.push_back(1);
      push_res(2, 3, 0);
      push_res(1, 1, 0);
      bus.req = 4'b0100;
      wait_gnt("t3");
      bus.req[1] = 1'b1;
      wait_valid("t3");
      for (int k = 0; k < 10; k++) begin
         check("t3_hold_valid", bus.res_valid, 1);
         check("t3_hold_code", bus.res_code, 3);
         check("t3_hold_ch", bus.res_ch, 2);
         check("t3_hold_gnt", bus.gnt, 4'b0100);
         @(negedge clk);
      end
      bus.res_ready = 1'b1;
      wait_hs("t3a");
      bus.req[2] = 1'b0;
      @(negedge clk);
      wait_hs("t3b");
      bus.req[1] = 1'b0;
      @(negedge clk);

      // abort: ch1 drops request mid-RUN after 0,1
      do_reset();
      set_pat(1, 8'b10, 2, 1'b1);
      exp_gnt_q.push_back(1);
      bus.req = 4'b0010;
      wait_gnt("t4");
      wait_run("t4");
      repeat (4) @(negedge clk);
      bus.req[1] = 1'b0;
      @(negedge clk);
      check("t4_abort_gnt", bus.gnt, 0);
      check("t4_abort_valid", bus.res_valid, 0);
      set_pat(1, 8'b010, 3, 1'b0);
      set_pat(2, 8'b010, 3, 1'b0);
      exp_gnt_q.push_back(2);
      exp_gnt_q.push_back(1);
      push_res(2, 1, 0);
      push_res(1, 1, 0);
      bus.req = 4'b0110;
      wait_hs("t4a");
      bus.req[2] = 1'b0;
      @(negedge clk);
      wait_hs("t4b");
      bus.req[1] = 1'b0;
      @(negedge clk);

      // asynchronous reset while a result is held
      do_reset();
      bus.res_ready = 1'b0;
      set_pat(0, 8'b010, 3, 1'b0);
      exp_gnt_q.push_back(0);
      bus.req = 4'b0001;
      wait_valid("t5");
      rst = 1'b1;
      #1;
      check("t5_async_valid", bus.res_valid, 0);
      check("t5_async_gnt", bus.gnt, 0);
      check("t5_async_det_rst", bus.det_rst, 1);
      #54;
      @(negedge clk);
      rst = 1'b0;
      set_pat(3, 8'b010, 3, 1'b0);
      exp_gnt_q.push_back(0);
      exp_gnt_q.push_back(3);
      push_res(0, 1, 0);
      push_res(3, 1, 0);
      bus.res_ready = 1'b1;
      bus.req = 4'b1001;
      wait_hs("t5a");
      bus.req[0] = 1'b0;
      @(negedge clk);
      wait_hs("t5b");
      bus.req[3] = 1'b0;
      @(negedge clk);

      // ch3 never produces a pattern
      do_reset();
      set_pat(3, 8'h00, 0, 1'b0);
      exp_gnt_q.push_back(3);
`ifdef DET_TIMEOUT_EN
      push_res(3, 0, 1);
      bus.req = 4'b1000;
      wait_gnt("t6");
      wait_run("t6");
      n = 0;
      while (!bus.res_valid && n < 200) begin
         n++;
         @(negedge clk);
      end
      check("t6_timeout_cycles", n, TIMEOUT);
      bus.req = '0;
      @(negedge clk);
`else
      bus.req = 4'b1000;
      wait_gnt("t6");
      seen = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (bus.res_valid) seen = 1'b1;
      end
      check("t6_no_result", seen, 0);
      bus.req = '0;
      repeat (2) @(negedge clk);
      check("t6_abort_gnt", bus.gnt, 0);
`endif
      repeat (2) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      check("gnt_q_empty", exp_gnt_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
